// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: UART-framed byte memory engine (READ/WRITE/FILL/PING) with inter-byte timeout.
// Build option UART_MEM_BRIDGE_CHECKSUM_EN adds an XOR checksum to READ and WRITE responses.
module uart_mem_bridge #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LEN_BYTES  = 1,
  parameter int unsigned TIMEOUT    = 65535,
  parameter logic [7:0]  ACK_BYTE   = 8'hAA
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  received,
  input  logic [7:0]            rx_byte,
  input  logic                  is_transmitting,
  output logic                  transmit,
  output logic [7:0]            tx_byte,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  busy,
  output logic [3:0]            dbg_state
);
  localparam int unsigned ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
  localparam int unsigned LW         = 8 * LEN_BYTES;

  localparam logic [1:0] CMD_PING  = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_RX_LEN, S_RX_ADDR, S_RX_FILL, S_READ_WAIT, S_READ, S_READ_ADV,
    S_WRITE_RX, S_WRITE_ADV, S_FILL_WR, S_FILL_ADV, S_TX_WAIT, S_TX
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [LW-1:0]         r_len, w_len_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [1:0]            r_cnt, w_cnt_nxt;
  logic [1:0]            r_cmd, w_cmd_nxt;
  logic [31:0]           r_tmo, w_tmo_nxt;
  logic [7:0]            r_tx_byte, w_tx_byte_nxt;
  logic [7:0]            r_wdata, w_wdata_nxt;
  logic                  r_transmit, w_transmit_nxt;
  logic                  r_mem_read, w_mem_read_nxt;
  logic                  r_mem_write, w_mem_write_nxt;
  logic                  w_tx_ok, w_len_zero, w_rx_state, w_tmo_hit;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
  logic [7:0]            r_csum, w_csum_nxt;
`endif

  // The UART raises is_transmitting one cycle after our strobe, so skip that blind cycle.
  assign w_tx_ok    = !is_transmitting && !r_transmit;
  assign w_len_zero = (r_len == '0);
  assign w_rx_state = (r_state == S_RX_LEN) || (r_state == S_RX_ADDR) ||
                      (r_state == S_RX_FILL) || (r_state == S_WRITE_RX);
  assign w_tmo_hit  = (TIMEOUT != 0) && w_rx_state && !received && (r_tmo == TIMEOUT - 1);

  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_addr_nxt      = r_addr;
    w_cnt_nxt       = r_cnt;
    w_cmd_nxt       = r_cmd;
    w_tmo_nxt       = r_tmo;
    w_tx_byte_nxt   = r_tx_byte;
    w_wdata_nxt     = r_wdata;
    w_transmit_nxt  = 1'b0;
    w_mem_read_nxt  = 1'b0;
    w_mem_write_nxt = 1'b0;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
    w_csum_nxt      = r_csum;
`endif
    if (received)        w_tmo_nxt = '0;
    else if (w_rx_state) w_tmo_nxt = r_tmo + 32'd1;

    case (r_state)
      S_IDLE: begin
        if (received && rx_byte >= 8'h01 && rx_byte <= 8'h04) begin
          w_cmd_nxt   = rx_byte[1:0];
          w_cnt_nxt   = '0;
          w_state_nxt = (rx_byte[1:0] == CMD_PING) ? S_TX_WAIT : S_RX_LEN;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
          w_csum_nxt  = '0;
`endif
        end
      end
      S_RX_LEN: begin
        if (received) begin
          w_len_nxt = LW'({r_len, rx_byte});
          if (r_cnt == 2'(LEN_BYTES - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_RX_ADDR;
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
      end
      S_RX_ADDR: begin
        if (received) begin
          // Shifting through the narrower register drops address bits above ADDR_WIDTH.
          w_addr_nxt = ADDR_WIDTH'({r_addr, rx_byte});
          if (r_cnt == 2'(ADDR_BYTES - 1)) begin
            w_cnt_nxt = '0;
            case (r_cmd)
              CMD_READ:  w_state_nxt = S_READ_WAIT;
              CMD_WRITE: w_state_nxt = S_WRITE_RX;
              default:   w_state_nxt = S_RX_FILL;
            endcase
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
      end
      S_RX_FILL: begin
        if (received) begin
          w_wdata_nxt = rx_byte;
          w_state_nxt = S_FILL_WR;
        end
      end
      S_READ_WAIT: begin
        if (w_tx_ok) begin
          w_mem_read_nxt = 1'b1;
          w_state_nxt    = S_READ;
        end
      end
      S_READ: begin
        w_tx_byte_nxt  = mem_rdata;
        w_transmit_nxt = 1'b1;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
        w_csum_nxt     = r_csum ^ mem_rdata;
        w_state_nxt    = w_len_zero ? S_TX_WAIT : S_READ_ADV;
`else
        w_state_nxt    = w_len_zero ? S_IDLE : S_READ_ADV;
`endif
      end
      S_READ_ADV, S_WRITE_ADV, S_FILL_ADV: begin
        w_addr_nxt = r_addr + ADDR_WIDTH'(1);
        w_len_nxt  = r_len - LW'(1);
        case (r_state)
          S_READ_ADV:  w_state_nxt = S_READ_WAIT;
          S_WRITE_ADV: w_state_nxt = S_WRITE_RX;
          default:     w_state_nxt = S_FILL_WR;
        endcase
      end
      S_WRITE_RX: begin
        if (received) begin
          w_mem_write_nxt = 1'b1;
          w_wdata_nxt     = rx_byte;
          w_state_nxt     = w_len_zero ? S_TX_WAIT : S_WRITE_ADV;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
          w_csum_nxt      = r_csum ^ rx_byte;
`endif
        end
      end
      S_FILL_WR: begin
        w_mem_write_nxt = 1'b1;
        w_state_nxt     = w_len_zero ? S_TX_WAIT : S_FILL_ADV;
      end
      S_TX_WAIT: begin
        if (w_tx_ok) begin
          w_transmit_nxt = 1'b1;
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
          w_tx_byte_nxt  = (r_cmd == CMD_READ || r_cmd == CMD_WRITE) ? r_csum : ACK_BYTE;
`else
          w_tx_byte_nxt  = ACK_BYTE;
`endif
          w_state_nxt    = S_TX;
        end
      end
      S_TX:    w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_tmo_hit) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_tmo       <= '0;
      r_tx_byte   <= '0;
      r_wdata     <= '0;
      r_transmit  <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_addr      <= w_addr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cmd       <= w_cmd_nxt;
      r_tmo       <= w_tmo_nxt;
      r_tx_byte   <= w_tx_byte_nxt;
      r_wdata     <= w_wdata_nxt;
      r_transmit  <= w_transmit_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
    end
  end

`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_csum <= '0;
    else       r_csum <= w_csum_nxt;
  end
`endif

  assign transmit  = r_transmit;
  assign tx_byte   = r_tx_byte;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;
endmodule

// File: tb/tb_uart_mem_bridge.sv
// Scoreboard bench for uart_mem_bridge: reference memory model, UART/memory responders, monitors.
module tb_uart_mem_bridge;
  logic        clk = 1'b0;
  logic        reset;
  logic        received, received2;
  logic [7:0]  rx_byte, rx_byte2;
  logic        is_transmitting, is_transmitting2;
  logic        transmit, transmit2;
  logic [7:0]  tx_byte, tx_byte2;
  logic        mem_read, mem_read2, mem_write, mem_write2;
  logic [15:0] mem_addr;
  logic [19:0] mem_addr2;
  logic [7:0]  mem_wdata, mem_wdata2, mem_rdata, mem_rdata2;
  logic        busy, busy2;
  logic [3:0]  dbg_state, dbg_state2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0]  env_mem [0:65535];
  logic [7:0]  ref_mem [0:65535];
  bit          env_init = 1'b0;
  logic [8:0]  exp_tx_q[$];
  logic [23:0] exp_wr_q[$];
  logic [15:0] exp_rd_q[$];
  logic [7:0]  exp_tx2_q[$];
  logic [19:0] exp_rd2_q[$];
  int          wr_cyc_q[$];
  int          last_rd_cyc = -10;
  int          uart_cnt = 0;
  bit          hold_busy = 1'b0;
  logic [7:0]  dq[$];
  logic [8:0]  m_et;
  logic [23:0] m_ew;
  logic [15:0] m_er;
  logic [19:0] m_er2;
  logic [7:0]  m_et2;

  uart_mem_bridge #(.ADDR_WIDTH(16), .LEN_BYTES(1), .TIMEOUT(100), .ACK_BYTE(8'hAA)) dut (
    .clk(clk), .reset(reset), .received(received), .rx_byte(rx_byte),
    .is_transmitting(is_transmitting), .transmit(transmit), .tx_byte(tx_byte),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  uart_mem_bridge #(.ADDR_WIDTH(20), .LEN_BYTES(2)) dut2 (
    .clk(clk), .reset(reset), .received(received2), .rx_byte(rx_byte2),
    .is_transmitting(is_transmitting2), .transmit(transmit2), .tx_byte(tx_byte2),
    .mem_read(mem_read2), .mem_write(mem_write2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .busy(busy2), .dbg_state(dbg_state2)
  );

  // ---------------- clock / environment ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_pat(input int i);
    return 8'(i * 37 + 11) ^ 8'(i >> 8);
  endfunction

  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < 65536; i++) env_mem[i] <= init_pat(i);
      env_init <= 1'b1;
    end else if (mem_write) begin
      env_mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata  = mem_read ? env_mem[mem_addr] : 8'h5C;
  assign mem_rdata2 = mem_read2 ? (mem_addr2[7:0] ^ 8'h3C) : 8'h00;

  // UART transmitter: busy from the cycle after a transmit strobe for a random time.
  always @(posedge clk) begin
    if (transmit)           uart_cnt <= int'($urandom_range(2, 9));
    else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
  end
  assign is_transmitting  = hold_busy || (uart_cnt != 0);
  assign is_transmitting2 = 1'b0;

  // ---------------- checking helpers ----------------
  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic note_unexpected(input string nm, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %0h expected nothing (cycle %0d)", nm, act, cyc);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (transmit || mem_read || mem_write)
        check_val("strobe_exclusive", int'(transmit) + int'(mem_read) + int'(mem_write), 1);
      if (mem_write) begin
        wr_cyc_q.push_back(cyc);
        if (exp_wr_q.size() == 0) note_unexpected("unexpected_write", {mem_addr, mem_wdata});
        else begin
          m_ew = exp_wr_q.pop_front();
          check_val("write_addr_data", {mem_addr, mem_wdata}, m_ew);
        end
      end
      if (mem_read) begin
        last_rd_cyc = cyc;
        if (exp_rd_q.size() == 0) note_unexpected("unexpected_read", mem_addr);
        else begin
          m_er = exp_rd_q.pop_front();
          check_val("read_addr", mem_addr, m_er);
        end
      end
      if (transmit) begin
        check_val("tx_while_uart_busy", is_transmitting, 0);
        if (exp_tx_q.size() == 0) note_unexpected("unexpected_tx", tx_byte);
        else begin
          m_et = exp_tx_q.pop_front();
          check_val("tx_byte", tx_byte, m_et[7:0]);
          if (m_et[8]) check_val("read_to_tx_latency", cyc - last_rd_cyc, 1);
        end
      end
      if (mem_write2) note_unexpected("dut2_unexpected_write", mem_addr2);
      if (mem_read2) begin
        if (exp_rd2_q.size() == 0) note_unexpected("dut2_unexpected_read", mem_addr2);
        else begin
          m_er2 = exp_rd2_q.pop_front();
          check_val("dut2_read_addr", mem_addr2, m_er2);
        end
      end
      if (transmit2) begin
        if (exp_tx2_q.size() == 0) note_unexpected("dut2_unexpected_tx", tx_byte2);
        else begin
          m_et2 = exp_tx2_q.pop_front();
          check_val("dut2_tx_byte", tx_byte2, m_et2);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b);
    if (!sel) begin received = 1'b1; rx_byte = b; end
    else      begin received2 = 1'b1; rx_byte2 = b; end
    @(negedge clk);
    received  = 1'b0;
    received2 = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy || busy2) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_val(nm, {busy2, busy}, 2'b00);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input int len, input logic [15:0] a);
    send_byte(0, cmd);
    send_byte(0, 8'(len));
    send_byte(0, a[15:8]);
    send_byte(0, a[7:0]);
  endtask

  // Frame senders: the reference model predicts every strobe and reply before the frame goes out.
  task automatic do_write(input logic [15:0] a, input int len);
    logic [7:0] x = 8'h00;
    for (int i = 0; i <= len; i++) begin
      exp_wr_q.push_back({a + 16'(i), dq[i]});
      ref_mem[a + 16'(i)] = dq[i];
      x ^= dq[i];
    end
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
    exp_tx_q.push_back({1'b0, x});
`else
    exp_tx_q.push_back({1'b0, 8'hAA});
`endif
    send_hdr(8'h02, len, a);
    for (int i = 0; i <= len; i++) begin
      idle(int'($urandom_range(1, 3)));
      send_byte(0, dq[i]);
    end
    wait_idle("write_done");
  endtask

  task automatic do_read(input logic [15:0] a, input int len);
    logic [7:0] x = 8'h00;
    for (int i = 0; i <= len; i++) begin
      exp_rd_q.push_back(a + 16'(i));
      exp_tx_q.push_back({1'b1, ref_mem[a + 16'(i)]});
      x ^= ref_mem[a + 16'(i)];
    end
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
    exp_tx_q.push_back({1'b0, x});
`endif
    send_hdr(8'h01, len, a);
    wait_idle("read_done");
  endtask

  task automatic do_fill(input logic [15:0] a, input int len, input logic [7:0] v);
    for (int i = 0; i <= len; i++) begin
      exp_wr_q.push_back({a + 16'(i), v});
      ref_mem[a + 16'(i)] = v;
    end
    exp_tx_q.push_back({1'b0, 8'hAA});
    wr_cyc_q.delete();
    send_hdr(8'h03, len, a);
    send_byte(0, v);
    wait_idle("fill_done");
    check_val("fill_write_count", wr_cyc_q.size(), len + 1);
    for (int i = 1; i < wr_cyc_q.size(); i++)
      check_val("fill_write_spacing", wr_cyc_q[i] - wr_cyc_q[i-1], 2);
  endtask

  task automatic do_ping();
    exp_tx_q.push_back({1'b0, 8'hAA});
    send_byte(0, 8'h04);
    check_val("ping_busy_rise", busy, 1);
    wait_idle("ping_done");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int op, len;
    logic [15:0] a;
    logic [7:0]  v;
    logic [7:0]  x2;

    for (int i = 0; i < 65536; i++) ref_mem[i] = init_pat(i);
    reset = 1'b1; received = 1'b0; received2 = 1'b0; rx_byte = 8'h00; rx_byte2 = 8'h00;
    idle(3);
    check_val("reset_strobes", {transmit, mem_read, mem_write, busy}, 4'b0000);
    check_val("reset_tx_byte", tx_byte, 8'h00);
    check_val("reset_mem_addr", mem_addr, 16'h0000);
    check_val("reset_mem_wdata", mem_wdata, 8'h00);
    reset = 1'b0;
    idle(2);

    // Directed frames from the test plan
    dq = '{8'h11, 8'h22, 8'h33};
    do_write(16'h1234, 2);
    do_read(16'h1234, 2);
    do_fill(16'hFFFF, 1, 8'h5A);
    check_val("wrap_ref_0000", ref_mem[0], 8'h5A);

    // Wider address / two length bytes on the second instance
    x2 = 8'h00;
    for (int i = 0; i < 2; i++) begin
      exp_rd2_q.push_back(20'hABCDE + 20'(i));
      exp_tx2_q.push_back(8'(8'hDE + 8'(i)) ^ 8'h3C);
      x2 ^= 8'(8'hDE + 8'(i)) ^ 8'h3C;
    end
`ifdef UART_MEM_BRIDGE_CHECKSUM_EN
    exp_tx2_q.push_back(x2);
`endif
    send_byte(1, 8'h01); send_byte(1, 8'h00); send_byte(1, 8'h01);
    send_byte(1, 8'h0A); send_byte(1, 8'hBC); send_byte(1, 8'hDE);
    check_val("dut2_busy", busy2, 1);
    wait_idle("dut2_done");

    // Randomized command mix
    for (int k = 0; k < 30; k++) begin
      op  = int'($urandom_range(0, 4));
      len = int'($urandom_range(0, 7));
      a   = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                        : 16'h4000 + 16'($urandom_range(0, 40));
      case (op)
        0: do_read(a, len);
        1: begin
          dq.delete();
          for (int i = 0; i <= len; i++) dq.push_back(8'($urandom));
          do_write(a, len);
        end
        2: do_fill(a, len, 8'($urandom));
        3: do_ping();
        default: begin
          v = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(5, 255));
          send_byte(0, v);
          idle(2);
          check_val("junk_ignored", busy, 0);
        end
      endcase
    end

    // Inter-byte timeout with TIMEOUT=100
    send_byte(0, 8'h02); send_byte(0, 8'h05); send_byte(0, 8'h00);
    idle(90);
    check_val("timeout_still_busy", busy, 1);
    idle(11);
    check_val("timeout_to_idle", busy, 0);
    do_ping();

    // Reset while a READ is stalled on a busy UART
    hold_busy = 1'b1;
    send_hdr(8'h01, 10, 16'h2000);
    idle(5);
    check_val("stalled_read_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_val("midreset_strobes", {transmit, mem_read, mem_write, busy}, 4'b0000);
    check_val("midreset_bytes", {tx_byte, mem_wdata, mem_addr}, 32'h0);
    idle(2);
    reset = 1'b0;
    hold_busy = 1'b0;
    send_byte(0, 8'h07);
    idle(20);
    check_val("post_reset_ignore_07", busy, 0);
    do_ping();
    dq = '{8'hC3};
    do_write(16'h0010, 0);
    do_read(16'h0010, 0);

    idle(5);
    check_val("tx_queue_drained", exp_tx_q.size(), 0);
    check_val("wr_queue_drained", exp_wr_q.size(), 0);
    check_val("rd_queue_drained", exp_rd_q.size(), 0);
    check_val("dut2_queues_drained", exp_tx2_q.size() + exp_rd2_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
